// File: rtl/dff_bist.sv
// Self-test engine for an external positive-edge D flip-flop.
// Streams PATTERN into D (LSB first), checks Q/Qbar one clock later, and reports errors.
module dff_bist #(
  parameter int             N       = 16,
  parameter logic [N-1:0]   PATTERN = N'(16'hA5C3),
  parameter int             ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             dut_d,
  input  logic             dut_q,
  input  logic             dut_qbar,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       fail_index
);

  localparam int               IDX_W   = $clog2(N);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(N - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             launch;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] next_idx;
  logic [IDX_W-1:0] chk_idx;
  logic             exp_bit;
  logic             chk_valid;
  logic             fail_seen;
  logic             mismatch;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          launch  = 1'b1;
        end
      end
      RUN:     if (idx == LAST) state_d = FLUSH;
      FLUSH:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign next_idx = idx + 1'b1;
  assign mismatch = chk_valid && ((dut_q != exp_bit) || (dut_qbar != ~exp_bit));

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      chk_idx    <= '0;
      exp_bit    <= 1'b0;
      chk_valid  <= 1'b0;
      fail_seen  <= 1'b0;
      dut_d      <= 1'b0;
      err_count  <= '0;
      fail_index <= '0;
    end else begin
      // Check stage: compares the bit launched one clock earlier.
      if (mismatch) begin
        if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
        if (!fail_seen) begin
          fail_index <= 8'(chk_idx);
          fail_seen  <= 1'b1;
        end
      end

      case (state_q)
        RUN: begin
          exp_bit   <= PATTERN[idx];
          chk_idx   <= idx;
          chk_valid <= 1'b1;
          idx       <= next_idx;
          dut_d     <= (idx == LAST) ? 1'b0 : PATTERN[next_idx];
        end
        FLUSH: begin
          chk_valid <= 1'b0;
          dut_d     <= 1'b0;
        end
        default: dut_d <= 1'b0;
      endcase

      // A new run discards previous results; bit 0 is driven in the first RUN cycle.
      if (launch) begin
        idx        <= '0;
        chk_valid  <= 1'b0;
        fail_seen  <= 1'b0;
        err_count  <= '0;
        fail_index <= '0;
        dut_d      <= PATTERN[0];
      end
    end
  end

  assign busy = (state_q == RUN) || (state_q == FLUSH);
  assign done = (state_q == DONE);
  assign pass = done && (err_count == '0);

endmodule
